// File: rtl/sprite_sched_pkg.sv
// rtl/sprite_sched_pkg.sv - shared constants and FSM encoding for the sprite scheduler
package sprite_sched_pkg;

    localparam int SLOT_CYCLES = 4;
    localparam int POS_W       = 8;
    localparam int MAX_SPRITES = 8;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_SLOT = 2'd1,
        SCHED_DONE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/sprite_pos_slot.sv
// rtl/sprite_pos_slot.sv - one sprite's position registers and beam comparators (SPRITE_SCHED_SHADOW_EN adds shadow copies)
module sprite_pos_slot
    import sprite_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [8:0]       hpos_i,
    input  logic [8:0]       vpos_i,
`ifdef SPRITE_SCHED_SHADOW_EN
    input  logic             vsync_rise_i,
`endif
    input  logic             wr_sel_i,
    input  logic [POS_W-1:0] wr_x_i,
    input  logic [POS_W-1:0] wr_y_i,
    input  logic             wr_vis_i,
    output logic             vstart_o,
    output logic             hstart_o
);

    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic             vis_q, vis_d;
    logic             vstart_q, hstart_q;

`ifdef SPRITE_SCHED_SHADOW_EN
    logic [POS_W-1:0] sx_q, sy_q;
    logic             svis_q;

    // Shadow registers take every write; the active copy only moves at frame start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sx_q   <= '0;
            sy_q   <= '0;
            svis_q <= 1'b0;
        end else if (wr_sel_i) begin
            sx_q   <= wr_x_i;
            sy_q   <= wr_y_i;
            svis_q <= wr_vis_i;
        end
    end

    // Active registers reload from the pre-write shadow on the vsync edge
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        vis_d = vis_q;
        if (vsync_rise_i) begin
            x_d   = sx_q;
            y_d   = sy_q;
            vis_d = svis_q;
        end
    end
`else
    // Writes land directly in the active registers
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        vis_d = vis_q;
        if (wr_sel_i) begin
            x_d   = wr_x_i;
            y_d   = wr_y_i;
            vis_d = wr_vis_i;
        end
    end
`endif

    // Active position state plus registered top-edge and left-edge strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q      <= '0;
            y_q      <= '0;
            vis_q    <= 1'b0;
            vstart_q <= 1'b0;
            hstart_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vis_q    <= vis_d;
            vstart_q <= vis_q && ({1'b0, y_q} == vpos_i) && (hpos_i == 9'd0);
            hstart_q <= ({1'b0, x_q} == hpos_i);
        end
    end

    assign vstart_o = vstart_q;
    assign hstart_o = hstart_q;

endmodule

// File: rtl/sprite_scheduler.sv
// rtl/sprite_scheduler.sv - sprite position store, strobe generation and hsync ROM time-sharing (SPRITE_SCHED_SHADOW_EN selects shadowed writes)
module sprite_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NSPRITES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8:0]            hpos,
    input  logic [8:0]            vpos,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  wr_en,
    input  logic [2:0]            wr_idx,
    input  logic [POS_W-1:0]      wr_x,
    input  logic [POS_W-1:0]      wr_y,
    input  logic                  wr_vis,
    output logic [NSPRITES-1:0]   vstart,
    output logic [NSPRITES-1:0]   hstart,
    output logic [NSPRITES-1:0]   load,
    input  logic [4*NSPRITES-1:0] rr_addr,
    output logic [3:0]            rom_addr,
    output logic [2:0]            rom_sel
);

    localparam logic [2:0] LAST_GRANT = 3'(NSPRITES - 1);
    localparam logic [1:0] LAST_CYC   = 2'(SLOT_CYCLES - 1);

    sched_state_e          state_q;
    logic [1:0]            cyc_q;
    logic [2:0]            grant_q;
    logic [NSPRITES-1:0]   load_q;
    logic [NSPRITES-1:0]   next_load;
    logic                  hsync_q;
    logic                  hsync_rise;

    assign hsync_rise = hsync && !hsync_q;

`ifdef SPRITE_SCHED_SHADOW_EN
    logic vsync_q;
    logic vsync_rise;

    // Previous vsync for frame-start detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign vsync_rise = vsync && !vsync_q;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    for (genvar k = 0; k < NSPRITES; k++) begin : g_slot
        logic wr_sel;
        assign wr_sel = wr_en && (wr_idx == 3'(k));

        sprite_pos_slot u_slot (
            .clk_i        (clk),
            .rst_ni       (reset),
            .hpos_i       (hpos),
            .vpos_i       (vpos),
`ifdef SPRITE_SCHED_SHADOW_EN
            .vsync_rise_i (vsync_rise),
`endif
            .wr_sel_i     (wr_sel),
            .wr_x_i       (wr_x),
            .wr_y_i       (wr_y),
            .wr_vis_i     (wr_vis),
            .vstart_o     (vstart[k]),
            .hstart_o     (hstart[k])
        );
    end

    // One-hot load for the renderer that owns the next slot
    always_comb begin
        next_load = '0;
        for (int k = 0; k < NSPRITES; k++) begin
            if (3'(k) == grant_q + 3'd1) begin
                next_load[k] = 1'b1;
            end
        end
    end

    // ROM sequencer: one pass of 4-cycle slots per hsync pulse, load pulse on each slot's first cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SCHED_IDLE;
            cyc_q   <= 2'd0;
            grant_q <= 3'd0;
            load_q  <= '0;
            hsync_q <= 1'b0;
        end else begin
            hsync_q <= hsync;
            load_q  <= '0;
            case (state_q)
                SCHED_IDLE: begin
                    if (hsync_rise) begin
                        state_q <= SCHED_SLOT;
                        cyc_q   <= 2'd0;
                        grant_q <= 3'd0;
                        load_q  <= NSPRITES'(1);
                    end
                end
                SCHED_SLOT: begin
                    cyc_q <= cyc_q + 2'd1;
                    if (cyc_q == LAST_CYC) begin
                        if (grant_q == LAST_GRANT) begin
                            state_q <= SCHED_DONE;
                        end else begin
                            grant_q <= grant_q + 3'd1;
                            load_q  <= next_load;
                        end
                    end
                end
                SCHED_DONE: begin
                    if (!hsync) begin
                        state_q <= SCHED_IDLE;
                    end
                end
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

    // Shared ROM address follows whichever renderer holds the grant
    always_comb begin
        rom_addr = 4'd0;
        for (int k = 0; k < NSPRITES; k++) begin
            if (grant_q == 3'(k)) begin
                rom_addr = rr_addr[4*k +: 4];
            end
        end
    end

    assign rom_sel = grant_q;
    assign load    = load_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// tb/tb_sprite_scheduler.sv - randomized self-checking bench for sprite_scheduler against a frame/time-slot model
module tb_sprite_scheduler;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [8:0]     hpos, vpos;
    logic           hsync, vsync;
    logic           wr_en;
    logic [2:0]     wr_idx;
    logic [7:0]     wr_x, wr_y;
    logic           wr_vis;
    logic [N-1:0]   vstart, hstart, load;
    logic [4*N-1:0] rr_addr;
    logic [3:0]     rom_addr;
    logic [2:0]     rom_sel;

    int checks = 0;
    int errors = 0;

    // reference model: sprite tables and a load-sequence time index
    logic [7:0]   m_ax [N];
    logic [7:0]   m_ay [N];
    logic         m_avis [N];
    logic [7:0]   m_sx [N];
    logic [7:0]   m_sy [N];
    logic         m_svis [N];
    int           m_phase;
    int           m_t;
    logic         m_prev_hs, m_prev_vs;
    logic [N-1:0] e_vstart, e_hstart, e_load;
    int           e_grant;

    sprite_scheduler #(.NSPRITES(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .hpos     (hpos),
        .vpos     (vpos),
        .hsync    (hsync),
        .vsync    (vsync),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_vis   (wr_vis),
        .vstart   (vstart),
        .hstart   (hstart),
        .load     (load),
        .rr_addr  (rr_addr),
        .rom_addr (rom_addr),
        .rom_sel  (rom_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [3:0] exp_rom_addr();
        logic [4*N-1:0] r;
        r = rr_addr;
        return r[4*e_grant +: 4];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_ax[k] = 8'd0; m_ay[k] = 8'd0; m_avis[k] = 1'b0;
            m_sx[k] = 8'd0; m_sy[k] = 8'd0; m_svis[k] = 1'b0;
        end
        m_phase = 0; m_t = 0; m_prev_hs = 1'b0; m_prev_vs = 1'b0;
        e_vstart = '0; e_hstart = '0; e_load = '0; e_grant = 0;
    endtask

    // advance one clock and update the model from the inputs seen at that edge
    task automatic step();
        logic vs_rise;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            e_vstart[k] = m_avis[k] && ({1'b0, m_ay[k]} == vpos) && (hpos == 9'd0);
            e_hstart[k] = ({1'b0, m_ax[k]} == hpos);
        end
        if (m_phase == 0) begin
            if (hsync && !m_prev_hs) begin
                m_phase = 1;
                m_t = 0;
            end
        end else if (m_phase == 1) begin
            if (m_t == 4*N-1) m_phase = 2;
            else m_t++;
        end else if (!hsync) begin
            m_phase = 0;
        end
        m_prev_hs = hsync;
        e_load = '0;
        if (m_phase == 1) begin
            e_grant = m_t / 4;
            if (m_t % 4 == 0) e_load[m_t/4] = 1'b1;
        end
        vs_rise = vsync && !m_prev_vs;
        m_prev_vs = vsync;
`ifdef SPRITE_SCHED_SHADOW_EN
        if (vs_rise) begin
            for (int k = 0; k < N; k++) begin
                m_ax[k] = m_sx[k]; m_ay[k] = m_sy[k]; m_avis[k] = m_svis[k];
            end
        end
        if (wr_en && wr_idx < 3'(N)) begin
            m_sx[wr_idx] = wr_x; m_sy[wr_idx] = wr_y; m_svis[wr_idx] = wr_vis;
        end
`else
        if (vs_rise) m_prev_vs = vsync;
        if (wr_en && wr_idx < 3'(N)) begin
            m_ax[wr_idx] = wr_x; m_ay[wr_idx] = wr_y; m_avis[wr_idx] = wr_vis;
        end
`endif
        #1;
    endtask

    task automatic test_reset();
        hpos = 9'd0; vpos = 9'd0; hsync = 1'b0; vsync = 1'b0;
        wr_en = 1'b0; wr_idx = 3'd0; wr_x = 8'd0; wr_y = 8'd0; wr_vis = 1'b0;
        rr_addr = 16'h4C21;
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        checks++;
        if ({vstart, hstart, load, rom_sel} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {vstart, hstart, load, rom_sel});
        end
        checks++;
        if (rom_addr !== 4'h1) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h required 1", rom_addr);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (vstart !== '0) begin
                errors++;
                $display("FAIL reset_no_vstart: got %b required 0", vstart);
            end
            checks++;
            if ({vstart, hstart, load, rom_addr, rom_sel} !== {e_vstart, e_hstart, e_load, exp_rom_addr(), 3'(e_grant)}) begin
                errors++;
                $display("FAIL reset_idle: got %h required %h", {vstart, hstart, load, rom_addr, rom_sel}, {e_vstart, e_hstart, e_load, exp_rom_addr(), 3'(e_grant)});
            end
        end
    endtask

    task automatic test_sprite1();
        int nv, nh;
        nv = 0; nh = 0;
        wr_en = 1'b1; wr_idx = 3'd1; wr_x = 8'd40; wr_y = 8'd30; wr_vis = 1'b1;
        hpos = 9'd100; vpos = 9'd100;
        step();
        wr_en = 1'b0;
        vsync = 1'b1; step();
        vsync = 1'b0; step();
        for (int v = 29; v <= 31; v++) begin
            for (int h = 0; h < 50; h++) begin
                vpos = 9'(v); hpos = 9'(h);
                step();
                if (vstart[1]) nv++;
                if (hstart[1]) nh++;
                checks++;
                if ({vstart, hstart} !== {e_vstart, e_hstart}) begin
                    errors++;
                    $display("FAIL sprite1_strobes v=%0d h=%0d: got %h required %h", v, h, {vstart, hstart}, {e_vstart, e_hstart});
                end
            end
        end
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL sprite1_vstart_count: got %0d required 1", nv);
        end
        checks++;
        if (nh != 3) begin
            errors++;
            $display("FAIL sprite1_hstart_count: got %0d required 3", nh);
        end
    endtask

    task automatic test_load_seq();
        logic [N-1:0] exp_ld;
        rr_addr = 16'($urandom);
        rr_addr[11:8] = 4'hA;
        hsync = 1'b0; step();
        hsync = 1'b1; step();
        for (int i = 1; i <= 4*N+4; i++) begin
            exp_ld = '0;
            if ((i-1) % 4 == 0 && (i-1)/4 < N) exp_ld[(i-1)/4] = 1'b1;
            checks++;
            if (load !== exp_ld) begin
                errors++;
                $display("FAIL load_timing +%0d: got %b required %b", i, load, exp_ld);
            end
            if (i >= 9 && i <= 12) begin
                checks++;
                if ({rom_addr, rom_sel} !== {4'hA, 3'd2}) begin
                    errors++;
                    $display("FAIL slot2_rom +%0d: got addr %h sel %0d required addr a sel 2", i, rom_addr, rom_sel);
                end
            end
            checks++;
            if ({load, rom_addr, rom_sel} !== {e_load, exp_rom_addr(), 3'(e_grant)}) begin
                errors++;
                $display("FAIL load_model +%0d: got %h required %h", i, {load, rom_addr, rom_sel}, {e_load, exp_rom_addr(), 3'(e_grant)});
            end
            step();
        end
        hsync = 1'b0; step();
    endtask

    task automatic test_long_hsync();
        int nloads;
        nloads = 0;
        hsync = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            nloads += $countones(load);
            checks++;
            if ({load, rom_addr, rom_sel} !== {e_load, exp_rom_addr(), 3'(e_grant)}) begin
                errors++;
                $display("FAIL long_hsync cyc %0d: got %h required %h", i, {load, rom_addr, rom_sel}, {e_load, exp_rom_addr(), 3'(e_grant)});
            end
        end
        checks++;
        if (nloads != N) begin
            errors++;
            $display("FAIL long_hsync_count: got %0d required %0d", nloads, N);
        end
        hsync = 1'b0; step(); step();
        hsync = 1'b1; step();
        checks++;
        if ({load, rom_sel} !== {N'(1), 3'd0}) begin
            errors++;
            $display("FAIL long_hsync_restart: got load %b sel %0d required load 0001 sel 0", load, rom_sel);
        end
        hsync = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        hpos = 9'd40; vpos = 9'd200;
        hsync = 1'b0; step();
        hsync = 1'b1; step();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if ({load, rom_sel} !== {e_load, 3'(e_grant)} || rom_sel !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_grant: got load %b sel %0d required sel 2", load, rom_sel);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({vstart, hstart, load, rom_sel} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h required 0", {vstart, hstart, load, rom_sel});
        end
        checks++;
        if (rom_addr !== rr_addr[3:0]) begin
            errors++;
            $display("FAIL reset_mid_rom_addr: got %h required %h", rom_addr, rr_addr[3:0]);
        end
        model_reset();
        hsync = 1'b0;
        reset = 1'b1;
        step();
        hsync = 1'b1; step();
        checks++;
        if ({load, rom_sel} !== {N'(1), 3'd0}) begin
            errors++;
            $display("FAIL reset_mid_restart: got load %b sel %0d required load 0001 sel 0", load, rom_sel);
        end
        hsync = 1'b0;
        vpos = 9'd30; hpos = 9'd0; step();
        checks++;
        if (vstart !== '0) begin
            errors++;
            $display("FAIL reset_mid_vis_cleared: got %b required 0", vstart);
        end
    endtask

    task automatic test_bad_idx();
        logic [7:0] old_x, old_y;
        for (int k = 0; k < N; k++) begin
            wr_en = 1'b1; wr_idx = 3'(k); wr_x = 8'($urandom_range(1, 254)); wr_y = 8'($urandom_range(1, 254)); wr_vis = 1'b1;
            step();
        end
        wr_en = 1'b0; vsync = 1'b1; step(); vsync = 1'b0; step();
        old_x = m_ax[2]; old_y = m_ay[2];
        wr_en = 1'b1; wr_idx = 3'd6; wr_x = 8'd255; wr_y = 8'd255; wr_vis = 1'b1; step();
        wr_idx = 3'd4; wr_x = 8'd7; wr_y = 8'd9; step();
        wr_idx = 3'd2; wr_x = 8'd255; wr_y = 8'd255; vsync = 1'b1; step();
        wr_en = 1'b0; vsync = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < 6; j++) begin
                case (j)
                    0: begin vpos = {1'b0, old_y}; hpos = 9'd0; end
                    1: begin vpos = 9'd255; hpos = 9'd0; end
                    2: begin vpos = 9'd9; hpos = 9'd0; end
                    3: begin vpos = 9'd300; hpos = {1'b0, old_x}; end
                    4: begin vpos = 9'd300; hpos = 9'd255; end
                    default: begin vpos = 9'd300; hpos = 9'd7; end
                endcase
                step();
                checks++;
                if ({vstart, hstart} !== {e_vstart, e_hstart}) begin
                    errors++;
                    $display("FAIL bad_idx_shadow pass %0d probe %0d: got %h required %h", pass, j, {vstart, hstart}, {e_vstart, e_hstart});
                end
            end
            vsync = 1'b1; step(); vsync = 1'b0; step();
        end
    endtask

    task automatic test_random();
        int k;
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, N-1));
            if ($urandom_range(0, 1) == 1) hpos = $urandom_range(0, 3) == 0 ? 9'd0 : {1'b0, m_ax[k]};
            else hpos = 9'($urandom);
            vpos = $urandom_range(0, 1) == 1 ? {1'b0, m_ay[k]} : 9'($urandom);
            if ($urandom_range(0, 19) == 0) hsync = ~hsync;
            if ($urandom_range(0, 39) == 0) vsync = ~vsync;
            wr_en = ($urandom_range(0, 9) == 0);
            wr_idx = 3'($urandom); wr_x = 8'($urandom); wr_y = 8'($urandom); wr_vis = 1'($urandom);
            if ($urandom_range(0, 15) == 0) rr_addr = 16'($urandom);
            step();
            checks++;
            if ({vstart, hstart, load, rom_addr, rom_sel} !== {e_vstart, e_hstart, e_load, exp_rom_addr(), 3'(e_grant)}) begin
                errors++;
                $display("FAIL random cyc %0d: got %h required %h", i, {vstart, hstart, load, rom_addr, rom_sel}, {e_vstart, e_hstart, e_load, exp_rom_addr(), 3'(e_grant)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_sprite1();
        test_load_seq();
        test_long_hsync();
        test_reset_mid();
        test_bad_idx();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
